// File: rtl/scr_arbiter.sv
// scr_arbiter: shares one synchronous screen RAM port between a display fetch
// engine (reads) and a host write path (buffered in a small FIFO).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   host_we/addr/data          host write strobe, queued into the FIFO
//   host_full, host_ovf        FIFO full (registered), sticky drop flag
//   ovf_clr                    clears host_ovf, wins over a same-cycle set
//   disp_req/addr, disp_ack    display read request and same-cycle grant
//   disp_valid, disp_data      read data, two cycles after disp_ack
//   ram_addr/wdata/we          registered RAM command
//   ram_q                      RAM read data for the address registered last cycle
//
// Reads win over writes, except when the display has won STARVE_MAX times in a
// row while a write was waiting; then one write is forced through.
module scr_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_full,
   output logic              host_ovf,
   input  logic              ovf_clr,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_ack,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_READ  = 2'd1,
      GNT_WRITE = 2'd2
   } grant_e;

   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              host_full_q, host_full_d;
   logic              host_ovf_q, host_ovf_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_we_q, ram_we_d;
   logic              rd_pend_q, rd_pend_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;

   grant_e grant;
   logic   fifo_empty;
   logic   push;
   logic   pop;

   always_comb begin
      fifo_empty   = (count_q == '0);
      push         = host_we & ~host_full_q;
      grant        = GNT_IDLE;
      fifo_addr_d  = fifo_addr_q;
      fifo_data_d  = fifo_data_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;
      rd_pend_d    = 1'b0;
      starve_d     = starve_q;
      host_ovf_d   = host_ovf_q;
      disp_valid_d = rd_pend_q;
      disp_data_d  = disp_data_q;

      // Starvation override only matters while a write is actually waiting.
      if (disp_req && !(starve_q == ST_MAX && !fifo_empty)) begin
         grant = GNT_READ;
      end else if (!fifo_empty) begin
         grant = GNT_WRITE;
      end
      pop = (grant == GNT_WRITE);

      case (grant)
         GNT_READ: begin
            ram_addr_d = disp_addr;
            rd_pend_d  = 1'b1;
         end
         GNT_WRITE: begin
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_data_q[rd_ptr_q];
            ram_we_d    = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
         end
         default: ;
      endcase

      if (push) begin
         fifo_addr_d[wr_ptr_q] = host_addr;
         fifo_data_d[wr_ptr_q] = host_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      host_full_d = (count_d == CNT_FULL);

      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (grant == GNT_READ && starve_q != ST_MAX) begin
         starve_d = starve_q + 1'b1;
      end

      if (ovf_clr) begin
         host_ovf_d = 1'b0;
      end else if (host_we && host_full_q) begin
         host_ovf_d = 1'b1;
      end

      // ram_q reflects the address registered for the read one cycle ago.
      if (rd_pend_q) begin
         disp_data_d = ram_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         host_full_q  <= 1'b0;
         host_ovf_q   <= 1'b0;
         starve_q     <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         rd_pend_q    <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
      end else begin
         fifo_addr_q  <= fifo_addr_d;
         fifo_data_q  <= fifo_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         host_full_q  <= host_full_d;
         host_ovf_q   <= host_ovf_d;
         starve_q     <= starve_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         rd_pend_q    <= rd_pend_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
      end
   end

   assign disp_ack   = (grant == GNT_READ) & rst_n;
   assign host_full  = host_full_q;
   assign host_ovf   = host_ovf_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign ram_we     = ram_we_q;
   assign disp_valid = disp_valid_q;
   assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_scr_arbiter.sv
module tb_scr_arbiter;

   localparam int DEPTH = 4;
   localparam int SMAX  = 8;
   localparam int LOGN  = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_data;
   logic        host_full;
   logic        host_ovf;
   logic        ovf_clr;
   logic        disp_req;
   logic [15:0] disp_addr;
   logic        disp_ack;
   logic        disp_valid;
   logic [7:0]  disp_data;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_q;

   scr_arbiter #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
      .host_full(host_full), .host_ovf(host_ovf), .ovf_clr(ovf_clr),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
      .disp_valid(disp_valid), .disp_data(disp_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Bench RAM: write on the clock, read of the registered address is combinational.
   logic [7:0] ram_mem [0:65535];
   always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;
   assign ram_q = ram_mem[ram_addr];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of pending writes, a starvation counter and the
   // expected RAM command / display data for the current cycle.
   typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
   ent_t       q[$];
   logic [7:0] shadow [0:65535];
   int         starve;
   logic       m_we, m_rd_pend, m_valid, m_ovf;
   logic [15:0] m_addr;
   logic [7:0] m_wdata, m_data;

   int   cyc = 0;
   logic ack_log [0:LOGN-1];
   logic we_log  [0:LOGN-1];
   logic [15:0] addr_log [0:LOGN-1];
   logic [7:0]  wd_log [0:LOGN-1];
   logic val_log [0:LOGN-1];
   logic [7:0]  dd_log [0:LOGN-1];
   logic full_log [0:LOGN-1];
   logic ovf_log [0:LOGN-1];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_disp_ack", disp_ack, 0);
         chk("rst_ram_we", ram_we, 0);
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_ram_wdata", ram_wdata, 0);
         chk("rst_disp_valid", disp_valid, 0);
         chk("rst_disp_data", disp_data, 0);
         chk("rst_host_full", host_full, 0);
         chk("rst_host_ovf", host_ovf, 0);
         q.delete();
         starve = 0; m_we = 0; m_rd_pend = 0; m_valid = 0; m_ovf = 0;
         m_addr = 0; m_wdata = 0; m_data = 0;
      end else begin
         bit   full, nonempty, rd, wr, v_n;
         logic [7:0] d_n;
         ent_t e;
         full     = (q.size() == DEPTH);
         nonempty = (q.size() > 0);
         chk("ram_we", ram_we, m_we);
         if (m_we) begin
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_wdata", ram_wdata, m_wdata);
         end
         chk("disp_valid", disp_valid, m_valid);
         if (m_valid) chk("disp_data", disp_data, m_data);
         chk("host_full", host_full, full);
         chk("host_ovf", host_ovf, m_ovf);

         rd = disp_req && !(nonempty && starve == SMAX);
         wr = !rd && nonempty;
         chk("disp_ack", disp_ack, rd);

         v_n = m_rd_pend;
         d_n = m_rd_pend ? shadow[m_addr] : m_data;
         if (m_we) shadow[m_addr] = m_wdata;
         if (rd) begin
            m_addr = disp_addr; m_we = 0; m_rd_pend = 1;
         end else if (wr) begin
            e = q.pop_front();
            m_addr = e.a; m_wdata = e.d; m_we = 1; m_rd_pend = 0;
         end else begin
            m_we = 0; m_rd_pend = 0;
         end
         if (!nonempty || wr) starve = 0;
         else if (rd && starve < SMAX) starve++;
         if (host_we && !full) q.push_back('{host_addr, host_data});
         if (ovf_clr) m_ovf = 0;
         else if (host_we && full) m_ovf = 1;
         m_valid = v_n;
         m_data  = d_n;
      end
      if (cyc < LOGN) begin
         ack_log[cyc] = disp_ack; we_log[cyc] = ram_we; addr_log[cyc] = ram_addr;
         wd_log[cyc] = ram_wdata; val_log[cyc] = disp_valid; dd_log[cyc] = disp_data;
         full_log[cyc] = host_full; ovf_log[cyc] = host_ovf;
      end
      cyc++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic idle_inputs();
      host_we = 0; ovf_clr = 0; disp_req = 0;
   endtask

   initial begin
      int s, nw;
      logic [11:0] ack_pat, exp_pat;
      for (int i = 0; i < 65536; i++) begin
         ram_mem[i] = 8'h00;
         shadow[i]  = 8'h00;
      end
      ram_mem[16'h0100] = 8'hC3;
      shadow[16'h0100]  = 8'hC3;
      rst_n = 0; host_we = 0; host_addr = 0; host_data = 0;
      ovf_clr = 0; disp_req = 0; disp_addr = 0;
      tick(3);
      rst_n = 1;
      tick(2);

      // Single write
      s = cyc;
      host_we = 1; host_addr = 16'h0012; host_data = 8'h5A;
      tick(); host_we = 0;
      tick(4);
      chk("wr_before", we_log[s+1], 0);
      chk("wr_we", we_log[s+2], 1);
      chk("wr_addr", addr_log[s+2], 16'h0012);
      chk("wr_data", wd_log[s+2], 8'h5A);
      chk("wr_width", we_log[s+3], 0);

      // Read latency
      s = cyc;
      disp_req = 1; disp_addr = 16'h0100;
      tick(); disp_req = 0;
      tick(4);
      chk("rd_ack", ack_log[s], 1);
      chk("rd_valid_early", val_log[s+1], 0);
      chk("rd_valid", val_log[s+2], 1);
      chk("rd_data", dd_log[s+2], 8'hC3);
      chk("rd_valid_width", val_log[s+3], 0);

      // Back-to-back reads
      s = cyc;
      disp_req = 1;
      for (int i = 0; i < 3; i++) begin
         disp_addr = 16'h0100 + 16'(i);
         tick();
      end
      disp_req = 0;
      tick(4);
      chk("b2b_valid", {val_log[s+2], val_log[s+3], val_log[s+4]}, 3'b111);

      // Overflow and ovf_clr priority
      s = cyc;
      disp_req = 1; disp_addr = 16'h0040;
      for (int i = 0; i < 5; i++) begin
         host_we = 1; host_addr = 16'h0200 + 16'(i); host_data = 8'h10 + 8'(i);
         tick();
      end
      host_we = 0;
      tick(2);
      host_we = 1; ovf_clr = 1; host_addr = 16'h0299; host_data = 8'hEE;
      tick();
      host_we = 0; ovf_clr = 0;
      tick();
      chk("ovf_full_3", full_log[s+3], 0);
      chk("ovf_full_4", full_log[s+4], 1);
      chk("ovf_set", ovf_log[s+5], 1);
      chk("ovf_sticky", ovf_log[s+7], 1);
      chk("ovf_still_full", full_log[s+7], 1);
      chk("ovf_clr_wins", ovf_log[s+8], 0);
      disp_req = 0;
      tick(10);

      // Starvation: one write queued under a constant read stream
      s = cyc;
      disp_req = 1; disp_addr = 16'h0100;
      host_we = 1; host_addr = 16'h0300; host_data = 8'h77;
      tick(); host_we = 0;
      tick(13);
      disp_req = 0;
      tick(3);
      for (int i = 0; i < 12; i++) ack_pat[11-i] = ack_log[s+i];
      exp_pat = 12'b1111_1111_1011;
      chk("starve_ack_pattern", ack_pat, exp_pat);
      chk("starve_we", we_log[s+10], 1);
      chk("starve_addr", addr_log[s+10], 16'h0300);

      // Reset with queued writes and reads in flight
      disp_req = 1; disp_addr = 16'h0100;
      for (int i = 0; i < 3; i++) begin
         host_we = 1; host_addr = 16'h0400 + 16'(i); host_data = 8'h30 + 8'(i);
         tick();
      end
      host_we = 0;
      tick();
      rst_n = 0; disp_req = 0;
      tick(2);
      rst_n = 1;
      s = cyc;
      tick(8);
      nw = 0;
      for (int i = 0; i < 8; i++) nw += int'(we_log[s+i]) + int'(val_log[s+i]) + int'(full_log[s+i]);
      chk("rst_quiet", nw, 0);

      // Wrap and order: ten writes separated by idle cycles
      s = cyc;
      for (int i = 0; i < 10; i++) begin
         host_we = 1; host_addr = 16'(i); host_data = 8'hA0 + 8'(i);
         tick();
         host_we = 0;
         tick();
      end
      tick(6);
      nw = 0;
      for (int i = s; i < cyc && i < LOGN; i++) begin
         if (we_log[i]) begin
            chk("order_addr", addr_log[i], 16'(nw));
            chk("order_data", wd_log[i], 8'hA0 + 8'(nw));
            nw++;
         end
      end
      chk("order_count", nw, 10);

      idle_inputs();
      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
